// File: rtl/w0rm_mem_bus_master_if.sv
// W0RM bus master signal bundle: CPU command/response handshakes plus the peripheral strobe bus.
// The master modport is the initiator's view; slave is the CPU/peripheral side.
interface w0rm_mem_bus_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;

    logic                  mem_valid_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic                  mem_valid_i;
    logic [DATA_WIDTH-1:0] mem_data_i;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, mem_valid_i, mem_data_i, rsp_ready,
        output cmd_ready, mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
        output rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, mem_valid_i, mem_data_i, rsp_ready,
        input  cmd_ready, mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
        input  rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/w0rm_mem_bus_master.sv
// W0RM peripheral bus initiator: one outstanding command, single-cycle bus strobe,
// read data capture with timeout, and a held response until the consumer accepts it.
module w0rm_mem_bus_master #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned TO_WIDTH   = 5
) (
    input  logic                          mem_clk,
    input  logic                          cpu_reset,
    w0rm_mem_bus_master_if.master         bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  timeout_hit;

    // Counter reads TIMEOUT-1 during the last permitted WAIT_RD cycle.
    assign timeout_hit = (cnt_q == TO_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge mem_clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    data_d  = bus.cmd_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d       = '0;
                rsp_data_d  = '0;
                rsp_error_d = 1'b0;
                state_d     = write_q ? StResp : StWaitRd;
            end
            StWaitRd: begin
                cnt_d = cnt_q + TO_WIDTH'(1);
                // Data arriving on the timeout cycle takes priority over the error.
                if (bus.mem_valid_i) begin
                    rsp_data_d  = bus.mem_data_i;
                    rsp_error_d = 1'b0;
                    state_d     = StResp;
                end else if (timeout_hit) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.cmd_ready   = 1'b0;
        bus.mem_valid_o = 1'b0;
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_data    = '0;
        bus.rsp_error   = 1'b0;
        unique case (state_q)
            StIdle: bus.cmd_ready = 1'b1;
            StIssue: begin
                bus.mem_valid_o = 1'b1;
                bus.mem_read_o  = ~write_q;
                bus.mem_write_o = write_q;
                bus.mem_addr_o  = addr_q;
                bus.mem_data_o  = data_q;
            end
            StWaitRd: ;
            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rsp_data_q;
                bus.rsp_error = rsp_error_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/w0rm_mem_bus_master.md
Name: w0rm_mem_bus_master

Overview:
- Initiator for the W0RM peripheral memory bus: turns single read/write commands from a CPU-side request port into one-cycle bus strobes (valid/read/write/addr/data).
- Collects read data from the addressed peripheral, or flags a timeout; returns the result on a held response port.
- Sits between the core's load/store unit and peripherals such as the counter and timers.
- One transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 8, bus data width.
- TIMEOUT, 16, maximum read-wait cycles before error (≥1).
- TO_WIDTH, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- mem_clk  in  1  single clock; all logic on rising edge.
- cpu_reset  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_data  in  DATA_WIDTH  write data.
- mem_valid_o  out  1  bus strobe, one cycle per transaction.
- mem_read_o  out  1  read qualifier.
- mem_write_o  out  1  write qualifier.
- mem_addr_o  out  ADDR_WIDTH  bus address.
- mem_data_o  out  DATA_WIDTH  bus write data.
- mem_valid_i  in  1  peripheral read-data valid.
- mem_data_i  in  DATA_WIDTH  peripheral read data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_error  out  1  read timed out.

Behaviour:
- Reset (cpu_reset low, async):
  - State = IDLE.
  - All outputs 0 except cmd_ready=1.
  - Timeout counter = 0.
  - Reset mid-transaction aborts it; no response is produced.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- cmd_ready = 1 only in IDLE.
- IDLE:
  - On cmd_valid & cmd_ready, latch write/addr/data → ISSUE.
- ISSUE (exactly one cycle):
  - mem_valid_o=1, mem_read_o=~write, mem_write_o=write, mem_addr_o/mem_data_o = latched values.
  - Read → WAIT_RD with counter cleared.
  - Write → RESP with rsp_data=0, rsp_error=0. Writes are posted; no peripheral ack.
- Strobe outputs outside ISSUE:
  - mem_valid_o/mem_read_o/mem_write_o = 0.
  - mem_addr_o/mem_data_o return to 0.
- WAIT_RD:
  - Counter increments each cycle.
  - mem_valid_i=1 → capture mem_data_i into rsp_data, rsp_error=0 → RESP.
  - Else, when counter reaches TIMEOUT-1 (i.e. TIMEOUT cycles in WAIT_RD without data) → rsp_data=0, rsp_error=1 → RESP.
  - mem_valid_i on the final (timeout) cycle wins: data is captured, no error.
- RESP:
  - rsp_valid=1; rsp_data/rsp_error held stable until rsp_ready=1.
  - rsp_ready=1 → IDLE, rsp_valid drops next cycle.
- mem_valid_i outside WAIT_RD (including the ISSUE cycle) is ignored. Peripherals register their response, so the earliest valid data arrives in the first WAIT_RD cycle.
- Latency:
  - Command accepted at edge N → strobe during cycle N+1.
  - Write: rsp_valid from N+2.
  - Read: data arriving in cycle M gives rsp_valid from M+1.
  - Minimum read-to-response = 3 cycles after accept.
- Throughput: with rsp_ready held high, back-to-back writes accept a new command every 3 cycles (IDLE→ISSUE→RESP→IDLE).
- A cmd_valid presented while not in IDLE stalls (cmd_ready=0); command fields must stay stable until accepted.

Test Plan:
- Write: cmd write addr=8'h04 data=8'hA5 → one-cycle strobe mem_valid_o=1, mem_write_o=1, mem_read_o=0, addr 04, data A5; rsp_valid two cycles after accept, rsp_data=00, rsp_error=0.
- Read with 2-cycle peripheral delay: read addr=8'h01, peripheral drives mem_valid_i/mem_data_i=8'h3C in the second WAIT_RD cycle → rsp_valid next cycle, rsp_data=3C, rsp_error=0.
- Timeout: read with TIMEOUT=16 and no mem_valid_i → exactly 16 WAIT_RD cycles, then rsp_valid=1, rsp_error=1, rsp_data=00. Repeat with mem_valid_i (data 8'h7E) on the 16th cycle → rsp_data=7E, rsp_error=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read response → rsp_valid/rsp_data stable, cmd_ready=0, a pending cmd_valid not accepted; raise rsp_ready → IDLE, pending command accepted the following cycle.
- Stray response: pulse mem_valid_i in IDLE and in the ISSUE cycle → no state change, no rsp_valid, correct data still captured later in WAIT_RD.
- Async reset in WAIT_RD: drop cpu_reset between clock edges → outputs clear immediately, cmd_ready=1 after release, no response emitted for the aborted read.
